// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access fault decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_e;

    // An access faults on an illegal funct3, a misaligned halfword/word,
    // or a word index beyond the end of data memory.
    function automatic logic lsu_fault(
        input logic              we,
        input logic [2:0]        funct3,
        input logic [31:0]       addr,
        input int unsigned       mem_words
    );
        logic bad_funct3;
        logic misaligned;
        logic out_of_range;
        if (we) begin
            bad_funct3 = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        end else begin
            bad_funct3 = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU));
        end
        misaligned   = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                       ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= mem_words);
        return bad_funct3 || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges sub-word store data into a word read from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes out of the read word.
    always_comb begin
        byte_sel = rd[7:0];
        case (byte_off)
            2'd0:    byte_sel = rd[7:0];
            2'd1:    byte_sel = rd[15:8];
            2'd2:    byte_sel = rd[23:16];
            default: byte_sel = rd[31:24];
        endcase
        half_sel = byte_off[1] ? rd[31:16] : rd[15:0];
    end

    // Sign- or zero-extend the selected lane according to funct3.
    always_comb begin
        load_data = rd;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rd;
        endcase
    end

    // Overwrite only the addressed byte lanes of the read word with store data.
    always_comb begin
        merged = wdata;
        case (funct3)
            F3_B: begin
                case (byte_off)
                    2'd0:    merged = {rd[31:8], wdata[7:0]};
                    2'd1:    merged = {rd[31:16], wdata[7:0], rd[7:0]};
                    2'd2:    merged = {rd[31:24], wdata[7:0], rd[15:0]};
                    default: merged = {wdata[7:0], rd[23:0]};
                endcase
            end
            F3_H:    merged = byte_off[1] ? {wdata[15:0], rd[15:0]} : {rd[31:16], wdata[15:0]};
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Handshake: a request is taken at a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and resp_valid
// pulses for one cycle when the access completes (resp_fault qualifies it).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        req_fault;

    assign req_fault = lsu_fault(req_we, req_funct3, req_addr, MEM_WORDS);

    lsu_align u_align (
        .funct3    (funct3_q),
        .byte_off  (addr_q[1:0]),
        .rd        (mem_rd),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Access sequencer; every output is registered so mem_we can only be
    // high in WRITE and reset drops it immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= 32'd0;
            mem_wd     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (!req_we) begin
                            state <= LOAD;
                            mem_a <= {2'b00, req_addr[31:2]};
                        end else if (req_funct3 == F3_W) begin
                            state  <= WRITE;
                            mem_a  <= {2'b00, req_addr[31:2]};
                            mem_we <= 1'b1;
                            mem_wd <= req_wdata;
                        end else begin
                            state <= RMW_READ;
                            mem_a <= {2'b00, req_addr[31:2]};
                        end
                    end
                end
                LOAD: begin
                    state      <= RESP;
                    mem_a      <= 32'd0;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= load_data;
                end
                RMW_READ: begin
                    state  <= WRITE;
                    mem_we <= 1'b1;
                    mem_wd <= merged;
                end
                WRITE: begin
                    state      <= RESP;
                    mem_we     <= 1'b0;
                    mem_wd     <= 32'd0;
                    mem_a      <= 32'd0;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_we     <= 1'b0;
                    mem_a      <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 32-word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:31];
    int          checks;
    int          errors;
    int          wr_cnt;
    int          rv_cnt;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, write on rising edge
    assign mem_rd = (mem_a < 32'd32) ? mem[mem_a[4:0]] : 32'd0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[4:0]] <= mem_wd;
            wr_cnt          <= wr_cnt + 1;
        end
        if (resp_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [4:0]  word;
        logic [31:0] pre_val;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[22];

    // Issue one request and return latency (edges from accept to the edge at
    // which resp_valid is seen) plus whether req_ready stayed low meanwhile.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic ready_low);
        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        lat       = 0;
        ready_low = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready) ready_low = 1'b0;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout: got no resp_valid within 10 cycles");
        end
    endtask

    // Abort an access with reset after 'cyc' negedges from accept.
    task automatic reset_mid(input logic [31:0] addr, input int cyc);
        int wr0;
        int rv0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = addr;
        req_wdata  = 32'h000000CC;
        @(posedge clk);
        wr0 = wr_cnt;
        rv0 = rv_cnt;
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_no_write", wr_cnt - wr0, 32'd0);
        check("rst_mid_no_resp", rv_cnt - rv0, 32'd0);
        check("rst_mid_word1", mem[1], 32'h11223344);
    endtask

    initial begin
        int          lat;
        logic        ready_low;
        int          wr0;
        string       tag;

        checks = 0;
        errors = 0;
        wr_cnt = 0;
        rv_cnt = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[0] = 32'h807060F0;
        mem[1] = 32'h11223344;

        // we, f3, addr, wdata, pre_en, word, pre_val, exp_rdata, fault, lat, wr, exp_word
        vecs[0]  = '{1'b0, 3'b000, 32'h00, 32'h0,        1'b0, 5'd0,  32'h0,        32'hFFFFFFF0, 1'b0, 2, 0, 32'h807060F0};
        vecs[1]  = '{1'b0, 3'b100, 32'h00, 32'h0,        1'b0, 5'd0,  32'h0,        32'h000000F0, 1'b0, 2, 0, 32'h807060F0};
        vecs[2]  = '{1'b0, 3'b001, 32'h02, 32'h0,        1'b0, 5'd0,  32'h0,        32'hFFFF8070, 1'b0, 2, 0, 32'h807060F0};
        vecs[3]  = '{1'b0, 3'b101, 32'h02, 32'h0,        1'b0, 5'd0,  32'h0,        32'h00008070, 1'b0, 2, 0, 32'h807060F0};
        vecs[4]  = '{1'b0, 3'b000, 32'h03, 32'h0,        1'b0, 5'd0,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h807060F0};
        vecs[5]  = '{1'b0, 3'b100, 32'h01, 32'h0,        1'b0, 5'd0,  32'h0,        32'h00000060, 1'b0, 2, 0, 32'h807060F0};
        vecs[6]  = '{1'b1, 3'b001, 32'h06, 32'h1234BEEF, 1'b1, 5'd1,  32'h11223344, 32'h0,        1'b0, 3, 1, 32'hBEEF3344};
        vecs[7]  = '{1'b1, 3'b000, 32'h05, 32'h123456AB, 1'b1, 5'd1,  32'h11223344, 32'h0,        1'b0, 3, 1, 32'h1122AB44};
        vecs[8]  = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b1, 5'd2,  32'h0,        32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 3'b010, 32'h08, 32'h0,        1'b0, 5'd2,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 3'b010, 32'h02, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1, 0, 32'h807060F0};
        vecs[11] = '{1'b1, 3'b001, 32'h03, 32'h0000FFFF, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1, 0, 32'h807060F0};
        vecs[12] = '{1'b0, 3'b011, 32'h00, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1, 0, 32'h807060F0};
        vecs[13] = '{1'b0, 3'b010, 32'h80, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1, 0, 32'h807060F0};
        vecs[14] = '{1'b1, 3'b100, 32'h04, 32'hFFFFFFFF, 1'b0, 5'd1,  32'h0,        32'h0,        1'b1, 1, 0, 32'h1122AB44};
        vecs[15] = '{1'b0, 3'b001, 32'h01, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1, 0, 32'h807060F0};
        vecs[16] = '{1'b0, 3'b010, 32'h7C, 32'h0,        1'b1, 5'd31, 32'h5A5A1234, 32'h5A5A1234, 1'b0, 2, 0, 32'h5A5A1234};
        vecs[17] = '{1'b1, 3'b000, 32'h7F, 32'h00000099, 1'b0, 5'd31, 32'h0,        32'h0,        1'b0, 3, 1, 32'h995A1234};
        vecs[18] = '{1'b0, 3'b101, 32'h7E, 32'h0,        1'b0, 5'd31, 32'h0,        32'h0000995A, 1'b0, 2, 0, 32'h995A1234};
        vecs[19] = '{1'b1, 3'b000, 32'h01, 32'h00000077, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 3, 1, 32'h807077F0};
        vecs[20] = '{1'b0, 3'b001, 32'h00, 32'h0,        1'b0, 5'd0,  32'h0,        32'h000077F0, 1'b0, 2, 0, 32'h807077F0};
        vecs[21] = '{1'b1, 3'b010, 32'h80, 32'h01010101, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1, 0, 32'h807077F0};

        // Reset
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_mem_a", mem_a, 32'd0);
        check("reset_mem_wd", mem_wd, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].pre_en) mem[vecs[i].word] = vecs[i].pre_val;
            wr0 = wr_cnt;
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, ready_low);
            tag = $sformatf("v%0d", i);
            check({tag, "_rdata"}, resp_rdata, vecs[i].exp_rdata);
            check({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, vecs[i].exp_fault});
            check({tag, "_latency"}, lat, vecs[i].exp_lat);
            check({tag, "_ready_low"}, {31'd0, ready_low}, 32'd1);
            @(negedge clk);
            check({tag, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
            check({tag, "_rdata_hold"}, resp_rdata, vecs[i].exp_rdata);
            check({tag, "_writes"}, wr_cnt - wr0, vecs[i].exp_wr);
            check({tag, "_word"}, mem[vecs[i].word], vecs[i].exp_word);
        end

        // Store immediately followed by a load of the same word
        do_req(1'b1, 3'b010, 32'h0C, 32'hCAFEF00D, lat, ready_low);
        check("b2b_store_latency", lat, 32'd2);
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, lat, ready_low);
        check("b2b_load_rdata", resp_rdata, 32'hCAFEF00D);
        check("b2b_load_latency", lat, 32'd2);

        // Reset during RMW_READ, then during WRITE of an SB to word 1
        mem[1] = 32'h11223344;
        reset_mid(32'h04, 1);
        reset_mid(32'h04, 2);

        // Unit still works after an aborted access
        do_req(1'b0, 3'b100, 32'h06, 32'h0, lat, ready_low);
        check("post_rst_rdata", resp_rdata, 32'h00000022);
        check("post_rst_latency", lat, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
